reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_if.sv | 30 +++
 rtl/reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_reset_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Reset sequencer bundle: software request, per-stage ready/reset and status.
// master = sequencer side, slave = the downstream/requester side.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] stage_rdy;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  busy;
  logic                  all_done;
  logic                  err;

  modport master (
    input  sw_rst_req,
    input  stage_rdy,
    output stage_rst_n,
    output busy,
    output all_done,
    output err
  );

  modport slave (
    output sw_rst_req,
    output stage_rdy,
    input  stage_rst_n,
    input  busy,
    input  all_done,
    input  err
  );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered release of NUM_STAGES reset domains, gated on per-stage ready.
// Optional ready-wait timeout (ERR state) enabled by RST_SEQ_TIMEOUT_EN.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYC    = 8,
  parameter int STAGE_DLY   = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  reset_sequencer_if.master  bus
);

  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [7:0]    HOLD_END = 8'(HOLD_CYC - 1);
  localparam logic [7:0]    DLY_END  = 8'(STAGE_DLY - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_STAGES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [7:0]    TMO_END  = 8'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    ASSERT,
    RELEASE,
    WAIT_RDY,
    WAIT_DLY,
    DONE
`ifdef RST_SEQ_TIMEOUT_EN
    , ERR
`endif
  } state_t;

  state_t                state, nxt;
  logic [KW-1:0]         k, k_d;
  logic [7:0]            cnt, cnt_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rdy_k;

  assign rdy_k = bus.stage_rdy[k];

  always_comb begin
    nxt     = state;
    k_d     = k;
    cnt_d   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    rst_n_d = rst_n_q;
    unique case (state)
      ASSERT: begin
        if (cnt >= HOLD_END) begin
          nxt        = RELEASE;
          k_d        = '0;
          cnt_d      = '0;
          rst_n_d[0] = 1'b1;
        end
      end
      // RELEASE is the cycle right after a stage's rise; it takes the
      // first ready sample so the stage pitch is STAGE_DLY+1 edges.
      RELEASE: begin
        cnt_d = '0;
        if (rdy_k)
          nxt = (k == K_LAST) ? DONE : WAIT_DLY;
        else
          nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
`ifdef RST_SEQ_TIMEOUT_EN
        if (cnt >= TMO_END) begin
          nxt     = ERR;
          rst_n_d = '0;
        end else
`endif
        if (rdy_k) begin
          cnt_d = '0;
          nxt   = (k == K_LAST) ? DONE : WAIT_DLY;
        end
      end
      WAIT_DLY: begin
        if (cnt >= DLY_END) begin
          k_d          = k + KW'(1);
          rst_n_d[k_d] = 1'b1;
          cnt_d        = '0;
          nxt          = RELEASE;
        end
      end
      DONE: begin
        cnt_d = cnt;
      end
`ifdef RST_SEQ_TIMEOUT_EN
      ERR: begin
        cnt_d   = cnt;
        rst_n_d = '0;
      end
`endif
      default: begin
        nxt     = ASSERT;
        cnt_d   = '0;
        rst_n_d = '0;
      end
    endcase
    if (bus.sw_rst_req && state != ASSERT) begin
      nxt     = ASSERT;
      k_d     = '0;
      cnt_d   = '0;
      rst_n_d = '0;
    end
    busy_d = (nxt != DONE);
`ifdef RST_SEQ_TIMEOUT_EN
    if (nxt == ERR) busy_d = 1'b0;
`endif
    done_d = (nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ASSERT;
      k       <= '0;
      cnt     <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= nxt;
      k       <= k_d;
      cnt     <= cnt_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (nxt == ERR);
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.stage_rst_n = rst_n_q;
  assign bus.busy        = busy_q;
  assign bus.all_done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output changes are queued
// with their edge number; a negedge monitor pops one per observed change.
module tb_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_en;
  logic [6:0] prev;
  ev_t  q[$];

  reset_sequencer_if #(.NUM_STAGES(4)) bus ();

  reset_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [6:0] cur_out();
    return {bus.stage_rst_n, bus.busy, bus.all_done, bus.err};
  endfunction

  function automatic void push(int c, logic [3:0] rn,
                               logic b, logic d, logic e);
    ev_t ev;
    ev.cyc = c;
    ev.val = {rn, b, d, e};
    q.push_back(ev);
  endfunction

  function automatic void seq_full(int t);
    push(t + 8,  4'b0001, 1'b1, 1'b0, 1'b0);
    push(t + 25, 4'b0011, 1'b1, 1'b0, 1'b0);
    push(t + 42, 4'b0111, 1'b1, 1'b0, 1'b0);
    push(t + 59, 4'b1111, 1'b1, 1'b0, 1'b0);
    push(t + 60, 4'b1111, 1'b0, 1'b1, 1'b0);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [6:0] c;
    ev_t        e;
    if (mon_en) begin
      c = cur_out();
      if (c !== prev) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%b", cyc, c);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.val !== c) begin
            failures++;
            $display("FAIL event cyc=%0d want_cyc=%0d got=%b want=%b",
                     cyc, e.cyc, c, e.val);
          end
        end
        prev = c;
      end
    end
  end

  initial begin
    int t;
    int s;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    prev     = '0;
    rst      = 1'b1;
    bus.sw_rst_req = 1'b0;
    bus.stage_rdy  = 4'b1111;
    tick(3);

    checks++;
    if (cur_out() !== 7'b0000_1_0_0) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", cur_out(), 7'b0000100);
    end

    // power-up sequence, all ready
    prev   = cur_out();
    mon_en = 1'b1;
    rst    = 1'b0;
    seq_full(cyc);
    tick(70);

    // one-cycle rst in DONE replays everything
    rst = 1'b1;
    push(cyc + 1, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;
    seq_full(cyc);
    tick(70);

    // stage 1 slow to come ready; stage 3 ready bit ignored meanwhile
    bus.stage_rdy  = 4'b1101;
    bus.sw_rst_req = 1'b1;
    push(cyc + 1, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick(1);
    bus.sw_rst_req = 1'b0;
    t = cyc;
    push(t + 8,  4'b0001, 1'b1, 1'b0, 1'b0);
    push(t + 25, 4'b0011, 1'b1, 1'b0, 1'b0);
    s = t + 60;
    tick(s - 1 - cyc);
    bus.stage_rdy = 4'b1111;
    push(s + 16, 4'b0111, 1'b1, 1'b0, 1'b0);
    push(s + 33, 4'b1111, 1'b1, 1'b0, 1'b0);
    push(s + 34, 4'b1111, 1'b0, 1'b1, 1'b0);
    tick(s + 40 - cyc);

    // ready loss while DONE has no effect
    bus.stage_rdy = 4'b0000;
    tick(10);
    bus.stage_rdy = 4'b1111;
    tick(2);

    // sw request during WAIT_DLY of stage 2, then one ignored in ASSERT
    bus.sw_rst_req = 1'b1;
    push(cyc + 1, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick(1);
    bus.sw_rst_req = 1'b0;
    t = cyc;
    push(t + 8,  4'b0001, 1'b1, 1'b0, 1'b0);
    push(t + 25, 4'b0011, 1'b1, 1'b0, 1'b0);
    push(t + 42, 4'b0111, 1'b1, 1'b0, 1'b0);
    push(t + 50, 4'b0000, 1'b1, 1'b0, 1'b0);
    seq_full(t + 50);
    tick(t + 49 - cyc);
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(2);
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(t + 50 + 70 - cyc);

    // stage 0 never ready
    bus.stage_rdy  = 4'b1110;
    bus.sw_rst_req = 1'b1;
    push(cyc + 1, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick(1);
    bus.sw_rst_req = 1'b0;
    t = cyc;
    push(t + 8, 4'b0001, 1'b1, 1'b0, 1'b0);
`ifdef RST_SEQ_TIMEOUT_EN
    push(t + 264, 4'b0000, 1'b0, 1'b0, 1'b1);
    tick(t + 270 - cyc);
    bus.sw_rst_req = 1'b1;
    push(cyc + 1, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(3);
`else
    tick(1010);
    checks++;
    if (cur_out() !== 7'b0001_1_0_0) begin
      failures++;
      $display("FAIL no_timeout_hold got=%b want=%b", cur_out(), 7'b0001100);
    end
`endif

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_events left=%0d want=0 next_cyc=%0d",
               q.size(), q[0].cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
